min_max_leds_decoder: RTL and testbench
=======================================

// Module: min_max_leds_decoder
// PURPOSE
//  Observer at the far end of the min/max LED-bar interface: samples the
//  2**VALSIZE LED vector and recovers the min, max and value settings that
//  produced it. In normal mode LEDs min..value are steadily on and
//  value+1..max blink with the oscillator, so the decoder needs successive
//  samples to separate value from max. Used in the bench and in the on-board
//  self-check path.
// PARAMETERS
//  VALSIZE     4  width of min/max/value; LED vector is 2**VALSIZE bits
//  STABLE_CNT  4  identical consecutive samples that mean "no blink" (value==max); >=2
// PORTS
//  clk_i           in   1           system clock, rising edge
//  rst_ni          in   1           asynchronous reset, active low
//  leds_i          in   2**VALSIZE  LED vector under observation
//  leds_valid_i    in   1           sample strobe; leds_i used only when 1
//  min_o           out  VALSIZE     decoded min (lowest lit index)
//  max_o           out  VALSIZE     decoded max
//  value_o         out  VALSIZE     decoded value
//  empty_o         out  1           last result was an all-off bar
//  result_valid_o  out  1           1-cycle pulse: min/max/value/empty updated
//  error_o         out  1           1-cycle pulse: non-contiguous sample seen
// BEHAVIOUR
//  Reset: async on rst_ni=0; all outputs 0, state IDLE, lo_r/hi_r/cnt_r cleared.
//  Classification of each accepted sample (combinational, per strobe):
//   EMPTY = all bits 0; CONTIG = single run of ones, lo..hi; BAD = >1 run.
//   All-ones vector is CONTIG with lo=0, hi=2**VALSIZE-1.
//  FSM states: IDLE (nothing stored), HAVE (lo_r, hi_r, cnt_r stored).
//  leds_valid_i=0: no state or output change; pulses return to 0.
//  EMPTY (any state): result, min/max/value=0, empty_o=1; -> IDLE.
//  BAD (any state): error_o pulse; outputs hold; -> IDLE.
//  CONTIG in IDLE: lo_r=lo, hi_r=hi, cnt_r=1; -> HAVE; no result.
//  CONTIG in HAVE, lo!=lo_r: settings changed; reload lo_r/hi_r, cnt_r=1;
//   no result, no error.
//  CONTIG in HAVE, lo==lo_r, hi!=hi_r: blink edge; result with min=lo,
//   max=max(hi,hi_r), value=min(hi,hi_r), empty_o=0; hi_r=hi, cnt_r=1.
//  CONTIG in HAVE, lo==lo_r, hi==hi_r: cnt_r+1, saturating at STABLE_CNT;
//   on the transition to STABLE_CNT emit one result min=lo, max=value=hi;
//   further identical samples give no further pulses.
//  Latency: result_valid_o/error_o assert in the cycle after the clk edge
//   sampling the deciding strobe (1-cycle registered); data outputs
//   update on the same edge and hold until the next result.
//  Back-to-back strobes every cycle supported, no stall.
//  Widths: lo/hi/min/max/value are VALSIZE-bit unsigned; compare unsigned;
//   cnt_r is $clog2(STABLE_CNT+1) bits.
//  Linear mode (0..value lit) decodes as min=0; all-on as 0/top/top.
//  result_valid_o and error_o never assert in the same cycle.
// TESTING (VALSIZE=4, STABLE_CNT=4, one strobe per cycle)
//  Blink: 16'h0FF8 then 16'h01F8 -> result min=3 max=11 value=8, empty=0
//  Stable: 16'h00F0 x5 -> one result after 4th: min=4 max=7 value=7; none on 5th
//  Empty: 16'h0000 -> result, empty_o=1, min=max=value=0
//  Bad: 16'h0505 -> error_o 1 cycle, outputs hold; then 16'h00F0 -> no result
//  Min change: 16'h00F0, 16'h0F00 -> no result, no error; 16'h0300 -> max=11 value=9
//  Reset mid-op: 16'h0FF8, rst_ni=0, release, 16'h01F8 -> outputs 0, no result

Source files
------------

// File: rtl/min_max_leds_decoder.sv
// Recovers min/max/value settings from the observed min/max LED bar.
// Blinking LEDs are resolved by comparing the top of successive contiguous samples.
module min_max_leds_decoder #(
    parameter int unsigned VALSIZE    = 4,
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [2**VALSIZE-1:0]   leds_i,
    input  logic                    leds_valid_i,
    output logic [VALSIZE-1:0]      min_o,
    output logic [VALSIZE-1:0]      max_o,
    output logic [VALSIZE-1:0]      value_o,
    output logic                    empty_o,
    output logic                    result_valid_o,
    output logic                    error_o
);

    localparam int unsigned NumLeds = 2**VALSIZE;
    localparam int unsigned CntW    = $clog2(STABLE_CNT + 1);
    localparam logic [CntW-1:0] CntStable = CntW'(STABLE_CNT);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);

    typedef enum logic [0:0] {StIdle, StHave} state_e;

    state_e               state_q, state_d;
    logic [VALSIZE-1:0]   lo_q, lo_d;
    logic [VALSIZE-1:0]   hi_q, hi_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [VALSIZE-1:0]   min_q, min_d;
    logic [VALSIZE-1:0]   max_q, max_d;
    logic [VALSIZE-1:0]   value_q, value_d;
    logic                 empty_q, empty_d;
    logic                 result_q, result_d;
    logic                 error_q, error_d;

    // Sample classification
    logic [VALSIZE-1:0]   lo;
    logic [VALSIZE-1:0]   hi;
    int unsigned          runs;
    logic                 is_empty;
    logic                 is_contig;
    logic                 is_bad;

    always_comb begin
        lo   = '0;
        hi   = '0;
        runs = 0;
        for (int i = NumLeds - 1; i >= 0; i--) begin
            if (leds_i[i]) lo = VALSIZE'(i);
        end
        for (int i = 0; i < NumLeds; i++) begin
            if (leds_i[i]) hi = VALSIZE'(i);
        end
        // A run starts wherever a lit LED has an unlit (or no) neighbour below it
        for (int i = 0; i < NumLeds; i++) begin
            if (leds_i[i] && (i == 0 || !leds_i[(i == 0) ? 0 : i - 1])) runs++;
        end
        is_empty  = (runs == 0);
        is_contig = (runs == 1);
        is_bad    = (runs > 1);
    end

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        cnt_d    = cnt_q;
        min_d    = min_q;
        max_d    = max_q;
        value_d  = value_q;
        empty_d  = empty_q;
        result_d = 1'b0;
        error_d  = 1'b0;

        if (leds_valid_i) begin
            if (is_empty) begin
                result_d = 1'b1;
                min_d    = '0;
                max_d    = '0;
                value_d  = '0;
                empty_d  = 1'b1;
                state_d  = StIdle;
            end else if (is_bad) begin
                error_d = 1'b1;
                state_d = StIdle;
            end else if (is_contig) begin
                unique case (state_q)
                    StIdle: begin
                        lo_d    = lo;
                        hi_d    = hi;
                        cnt_d   = CntOne;
                        state_d = StHave;
                    end
                    StHave: begin
                        if (lo != lo_q) begin
                            lo_d  = lo;
                            hi_d  = hi;
                            cnt_d = CntOne;
                        end else if (hi != hi_q) begin
                            result_d = 1'b1;
                            min_d    = lo;
                            max_d    = (hi > hi_q) ? hi : hi_q;
                            value_d  = (hi > hi_q) ? hi_q : hi;
                            empty_d  = 1'b0;
                            hi_d     = hi;
                            cnt_d    = CntOne;
                        end else if (cnt_q < CntStable) begin
                            cnt_d = cnt_q + CntOne;
                            if (cnt_d == CntStable) begin
                                result_d = 1'b1;
                                min_d    = lo;
                                max_d    = hi;
                                value_d  = hi;
                                empty_d  = 1'b0;
                            end
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            lo_q     <= '0;
            hi_q     <= '0;
            cnt_q    <= '0;
            min_q    <= '0;
            max_q    <= '0;
            value_q  <= '0;
            empty_q  <= 1'b0;
            result_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            cnt_q    <= cnt_d;
            min_q    <= min_d;
            max_q    <= max_d;
            value_q  <= value_d;
            empty_q  <= empty_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign min_o          = min_q;
    assign max_o          = max_q;
    assign value_o        = value_q;
    assign empty_o        = empty_q;
    assign result_valid_o = result_q;
    assign error_o        = error_q;

endmodule

// File: tb/tb_min_max_leds_decoder.sv
// Directed bench for min_max_leds_decoder with hand-computed expectations.
module tb_min_max_leds_decoder;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] leds = '0;
    logic        leds_valid = 1'b0;
    logic [3:0]  min_v, max_v, value_v;
    logic        empty, result_valid, error;

    int checks = 0;
    int failures = 0;

    min_max_leds_decoder #(.VALSIZE(4), .STABLE_CNT(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .leds_i         (leds),
        .leds_valid_i   (leds_valid),
        .min_o          (min_v),
        .max_o          (max_v),
        .value_o        (value_v),
        .empty_o        (empty),
        .result_valid_o (result_valid),
        .error_o        (error)
    );

    always #5 clk = ~clk;

    // Drive one strobe; return sampled just after the capturing edge
    task automatic send(input logic [15:0] v);
        @(negedge clk);
        leds       = v;
        leds_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        leds_valid = 1'b0;
        leds       = 16'hA5A5;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({min_v, max_v, value_v, empty, result_valid, error} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {min_v, max_v, value_v, empty, result_valid, error});
        end
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_blink();
        send(16'h0FF8);
        checks++;
        if (result_valid !== 1'b0) begin
            failures++;
            $display("FAIL blink_first_no_result got=%b want=0", result_valid);
        end
        send(16'h01F8);
        checks++;
        if ({result_valid, error, min_v, max_v, value_v, empty} !== {2'b10, 4'd3, 4'd11, 4'd8, 1'b0})
        begin
            failures++;
            $display("FAIL blink_result got rv=%b err=%b min=%0d max=%0d val=%0d empty=%b want 1 0 3 11 8 0",
                     result_valid, error, min_v, max_v, value_v, empty);
        end
        idle();
        checks++;
        if (result_valid !== 1'b0 || min_v !== 4'd3 || max_v !== 4'd11 || value_v !== 4'd8) begin
            failures++;
            $display("FAIL blink_pulse_hold got rv=%b min=%0d max=%0d val=%0d want 0 3 11 8",
                     result_valid, min_v, max_v, value_v);
        end
    endtask

    task automatic test_stable();
        for (int i = 1; i <= 5; i++) begin
            send(16'h00F0);
            checks++;
            if (result_valid !== (i == 4)) begin
                failures++;
                $display("FAIL stable_pulse_%0d got=%b want=%b", i, result_valid, (i == 4));
            end
            if (i == 4) begin
                checks++;
                if ({min_v, max_v, value_v, empty} !== {4'd4, 4'd7, 4'd7, 1'b0}) begin
                    failures++;
                    $display("FAIL stable_values got min=%0d max=%0d val=%0d empty=%b want 4 7 7 0",
                             min_v, max_v, value_v, empty);
                end
            end
        end
    endtask

    task automatic test_empty();
        send(16'h0000);
        checks++;
        if ({result_valid, error, empty, min_v, max_v, value_v} !== {3'b101, 12'd0}) begin
            failures++;
            $display("FAIL empty_result got rv=%b err=%b empty=%b min=%0d max=%0d val=%0d want 1 0 1 0 0 0",
                     result_valid, error, empty, min_v, max_v, value_v);
        end
    endtask

    task automatic test_bad();
        send(16'h0505);
        checks++;
        if ({error, result_valid, empty, min_v, max_v, value_v} !== {3'b101, 12'd0}) begin
            failures++;
            $display("FAIL bad_error got err=%b rv=%b empty=%b min=%0d max=%0d val=%0d want 1 0 1 0 0 0",
                     error, result_valid, empty, min_v, max_v, value_v);
        end
        send(16'h00F0);
        checks++;
        if (result_valid !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL bad_then_contig got rv=%b err=%b want 0 0", result_valid, error);
        end
    endtask

    task automatic test_min_change();
        send(16'h00F0);
        send(16'h0F00);
        checks++;
        if (result_valid !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL min_change_quiet got rv=%b err=%b want 0 0", result_valid, error);
        end
        send(16'h0300);
        checks++;
        if ({result_valid, min_v, max_v, value_v} !== {1'b1, 4'd8, 4'd11, 4'd9}) begin
            failures++;
            $display("FAIL min_change_result got rv=%b min=%0d max=%0d val=%0d want 1 8 11 9",
                     result_valid, min_v, max_v, value_v);
        end
    endtask

    // All-on bar followed by a linear bar: blink between top and value
    task automatic test_full_and_linear();
        send(16'hFFFF);
        checks++;
        if (result_valid !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL full_contig got rv=%b err=%b want 0 0", result_valid, error);
        end
        send(16'h001F);
        checks++;
        if ({result_valid, min_v, max_v, value_v} !== {1'b1, 4'd0, 4'd15, 4'd4}) begin
            failures++;
            $display("FAIL linear_result got rv=%b min=%0d max=%0d val=%0d want 1 0 15 4",
                     result_valid, min_v, max_v, value_v);
        end
    endtask

    task automatic test_valid_gaps();
        send(16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++;
            if (result_valid !== 1'b0) begin
                failures++;
                $display("FAIL gap_idle_%0d got rv=%b want 0", i, result_valid);
            end
        end
        send(16'hFFFF);
        send(16'hFFFF);
        send(16'hFFFF);
        checks++;
        if ({result_valid, min_v, max_v, value_v} !== {1'b1, 4'd0, 4'd15, 4'd15}) begin
            failures++;
            $display("FAIL gap_full_stable got rv=%b min=%0d max=%0d val=%0d want 1 0 15 15",
                     result_valid, min_v, max_v, value_v);
        end
    endtask

    task automatic test_reset_mid_op();
        send(16'h0FF8);
        @(negedge clk);
        leds_valid = 1'b0;
        rst_ni     = 1'b0;
        #1;
        checks++;
        if ({min_v, max_v, value_v, empty, result_valid, error} !== 15'd0) begin
            failures++;
            $display("FAIL async_reset got=%h want=0",
                     {min_v, max_v, value_v, empty, result_valid, error});
        end
        @(negedge clk);
        rst_ni = 1'b1;
        send(16'h01F8);
        checks++;
        if ({result_valid, error, min_v, max_v, value_v} !== 14'd0) begin
            failures++;
            $display("FAIL reset_mid_op got rv=%b err=%b min=%0d max=%0d val=%0d want all 0",
                     result_valid, error, min_v, max_v, value_v);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_blink();
        test_stable();
        test_empty();
        test_bad();
        test_min_change();
        test_full_and_linear();
        test_valid_gaps();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
